// File: rtl/display_pkg.sv
// Shared constants for the seven-segment register display: segment codes,
// the hex glyph table and the register-select encodings.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [1:0] SEL_A0 = 2'd0;
    localparam logic [1:0] SEL_V0 = 2'd1;
    localparam logic [1:0] SEL_SP = 2'd2;
    localparam logic [1:0] SEL_RA = 2'd3;

    function automatic logic [3:0] nibble_of(input logic [15:0] val, input logic [1:0] idx);
        return val[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/reg_display_scanner_if.sv
// Debug-register inputs and display pin outputs of the register scanner.
interface reg_display_scanner_if;

    logic [15:0] a0;
    logic [15:0] v0;
    logic [15:0] sp;
    logic [15:0] ra;
    logic [1:0]  sel;
    logic        freeze;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output a0, v0, sp, ra, sel, freeze,
        input  an, seg, dp
    );

    modport slave (
        input  a0, v0, sp, ra, sel, freeze,
        output an, seg, dp
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to active-low seven-segment decoder with blanking.
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/reg_display_scanner.sv
// Multiplexed 4-digit hex display of one CPU debug register; the shown value
// and select are latched only at frame end so a frame never mixes two values.
module reg_display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_display_scanner_if.slave  bus
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [15:0]      shown_val_q, shown_val_d;
    logic [1:0]       shown_sel_q, shown_sel_d;

    logic        tc;
    logic        frame_end;
    logic [15:0] selected;
    logic        upper_zero;
    logic [6:0]  seg_w;

    assign tc        = (div_cnt_q == CNT_LAST);
    assign frame_end = tc && (digit_idx_q == 2'd3);

    always_comb begin
        selected = bus.a0;
        case (bus.sel)
            SEL_A0:  selected = bus.a0;
            SEL_V0:  selected = bus.v0;
            SEL_SP:  selected = bus.sp;
            SEL_RA:  selected = bus.ra;
            default: selected = bus.a0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        div_cnt_d   = div_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        shown_val_d = shown_val_q;
        shown_sel_d = shown_sel_q;
        if (tc) begin
            div_cnt_d   = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end
        if (frame_end && !bus.freeze) begin
            shown_sel_d = bus.sel;
            shown_val_d = selected;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 2'd0;
            shown_val_q <= 16'h0000;
            shown_sel_q <= SEL_A0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            shown_val_q <= shown_val_d;
            shown_sel_q <= shown_sel_d;
        end
    end

    // Digit i is a leading zero when nibbles i..3 are all zero; digit 0 never is.
    always_comb begin
        upper_zero = 1'b0;
        case (digit_idx_q)
            2'd1:    upper_zero = (shown_val_q[15:4]  == 12'h000);
            2'd2:    upper_zero = (shown_val_q[15:8]  == 8'h00);
            2'd3:    upper_zero = (shown_val_q[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_of(shown_val_q, digit_idx_q)),
        .blank  (BLANK_LZ && upper_zero),
        .seg    (seg_w)
    );

    assign bus.an  = ~(4'b0001 << digit_idx_q);
    assign bus.seg = seg_w;
    assign bus.dp  = (digit_idx_q != shown_sel_q);

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner with SCAN_DIV = 4; runs one instance
// with leading-zero blanking and one without, on identical stimulus.
module tb_reg_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a0, v0, sp, ra;
    logic [1:0]  sel;
    logic        freeze;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    reg_display_scanner_if if_lz ();
    reg_display_scanner_if if_nz ();

    assign if_lz.a0 = a0;  assign if_lz.v0 = v0;  assign if_lz.sp = sp;  assign if_lz.ra = ra;
    assign if_lz.sel = sel;  assign if_lz.freeze = freeze;
    assign if_nz.a0 = a0;  assign if_nz.v0 = v0;  assign if_nz.sp = sp;  assign if_nz.ra = ra;
    assign if_nz.sel = sel;  assign if_nz.freeze = freeze;

    reg_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_lz (
        .clk   (clk),
        .reset (reset),
        .bus   (if_lz)
    );

    reg_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nz (
        .clk   (clk),
        .reset (reset),
        .bus   (if_nz)
    );

    always #5 clk = ~clk;

    wire [11:0] obs_lz = {if_lz.an, if_lz.seg, if_lz.dp};
    wire [11:0] obs_nz = {if_nz.an, if_nz.seg, if_nz.dp};

    // Expected values are packed {an[3:0], seg[6:0], dp}.
    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_both(input string tag, input logic [11:0] e_lz, input logic [11:0] e_nz);
        check({tag, "/lz"}, obs_lz, e_lz);
        check({tag, "/nz"}, obs_nz, e_nz);
    endtask

    // Advance to cycle c (c edges after reset release), sampling 1 time unit after the edge.
    task automatic go_to(input int c);
        if (cyc < c) begin
            repeat (c - cyc) @(posedge clk);
            cyc = c;
            #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        a0     = 16'h0000;
        v0     = 16'h1234;
        sp     = 16'h0000;
        ra     = 16'h0000;
        sel    = 2'd1;
        freeze = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_both("reset_hold", {4'b1110, 7'b1000000, 1'b0}, {4'b1110, 7'b1000000, 1'b0});
        reset = 1'b0;
        cyc   = 0;

        go_to(1);
        check_both("post_release", {4'b1110, 7'b1000000, 1'b0}, {4'b1110, 7'b1000000, 1'b0});
        go_to(15);
        check_both("pre_first_sample", {4'b0111, 7'b1111111, 1'b1}, {4'b0111, 7'b1000000, 1'b1});

        // v0 = 1234 shown from cycle 16 with dp on digit 1.
        go_to(16);
        check_both("v0_d0", {4'b1110, 7'b0011001, 1'b1}, {4'b1110, 7'b0011001, 1'b1});
        go_to(17);
        sel = 2'd0;
        a0  = 16'h0042;
        go_to(20);
        check_both("v0_d1", {4'b1101, 7'b0110000, 1'b0}, {4'b1101, 7'b0110000, 1'b0});
        go_to(24);
        check_both("v0_d2", {4'b1011, 7'b0100100, 1'b1}, {4'b1011, 7'b0100100, 1'b1});
        go_to(28);
        check_both("v0_d3", {4'b0111, 7'b1111001, 1'b1}, {4'b0111, 7'b1111001, 1'b1});

        // a0 = 0042: leading-zero blanking on digits 2 and 3.
        go_to(32);
        check_both("a0_d0", {4'b1110, 7'b0100100, 1'b0}, {4'b1110, 7'b0100100, 1'b0});
        go_to(33);
        sel = 2'd2;
        sp  = 16'hBEEF;
        go_to(36);
        check_both("a0_d1", {4'b1101, 7'b0011001, 1'b1}, {4'b1101, 7'b0011001, 1'b1});
        go_to(40);
        check_both("a0_d2", {4'b1011, 7'b1111111, 1'b1}, {4'b1011, 7'b1000000, 1'b1});
        go_to(44);
        check_both("a0_d3", {4'b0111, 7'b1111111, 1'b1}, {4'b0111, 7'b1000000, 1'b1});

        // sp = BEEF, then freeze across three frame ends.
        go_to(48);
        check_both("sp_d0", {4'b1110, 7'b0001110, 1'b1}, {4'b1110, 7'b0001110, 1'b1});
        go_to(49);
        freeze = 1'b1;
        sp     = 16'h0001;
        sel    = 2'd3;
        ra     = 16'hCAFE;
        go_to(56);
        check_both("sp_d2", {4'b1011, 7'b0000110, 1'b0}, {4'b1011, 7'b0000110, 1'b0});
        go_to(96);
        check_both("frz_d0", {4'b1110, 7'b0001110, 1'b1}, {4'b1110, 7'b0001110, 1'b1});
        go_to(100);
        check_both("frz_d1", {4'b1101, 7'b0000110, 1'b1}, {4'b1101, 7'b0000110, 1'b1});
        go_to(104);
        check_both("frz_d2", {4'b1011, 7'b0000110, 1'b0}, {4'b1011, 7'b0000110, 1'b0});
        go_to(108);
        check_both("frz_d3", {4'b0111, 7'b0000011, 1'b1}, {4'b0111, 7'b0000011, 1'b1});
        go_to(109);
        freeze = 1'b0;

        // ra = CAFE after unfreeze; then only frame-end samples of ra may appear.
        go_to(112);
        check_both("ra_d0", {4'b1110, 7'b0000110, 1'b1}, {4'b1110, 7'b0000110, 1'b1});
        go_to(116);
        check_both("ra_d1", {4'b1101, 7'b0001110, 1'b1}, {4'b1101, 7'b0001110, 1'b1});
        ra = 16'h1111;
        go_to(124);
        check_both("ra_d3", {4'b0111, 7'b1000110, 1'b0}, {4'b0111, 7'b1000110, 1'b0});
        go_to(126);
        ra = 16'h5A96;
        go_to(128);
        check_both("iso1_d0", {4'b1110, 7'b0000010, 1'b1}, {4'b1110, 7'b0000010, 1'b1});
        go_to(132);
        check_both("iso1_d1", {4'b1101, 7'b0010000, 1'b1}, {4'b1101, 7'b0010000, 1'b1});
        go_to(136);
        check_both("iso1_d2", {4'b1011, 7'b0001000, 1'b1}, {4'b1011, 7'b0001000, 1'b1});
        ra = 16'h0070;
        go_to(140);
        check_both("iso1_d3", {4'b0111, 7'b0010010, 1'b0}, {4'b0111, 7'b0010010, 1'b0});
        go_to(144);
        check_both("iso2_d0", {4'b1110, 7'b1000000, 1'b1}, {4'b1110, 7'b1000000, 1'b1});
        go_to(148);
        check_both("iso2_d1", {4'b1101, 7'b1111000, 1'b1}, {4'b1101, 7'b1111000, 1'b1});
        go_to(152);
        check_both("iso2_d2", {4'b1011, 7'b1111111, 1'b1}, {4'b1011, 7'b1000000, 1'b1});
        go_to(156);
        check_both("iso2_d3", {4'b0111, 7'b1111111, 1'b0}, {4'b0111, 7'b1000000, 1'b0});

        // Asynchronous reset pulse at digit 2, count 2, entirely between clock edges.
        go_to(170);
        check_both("pre_async", {4'b1011, 7'b1111111, 1'b1}, {4'b1011, 7'b1000000, 1'b1});
        #2 reset = 1'b1;
        #1;
        check_both("async_reset", {4'b1110, 7'b1000000, 1'b0}, {4'b1110, 7'b1000000, 1'b0});
        #1 reset = 1'b0;
        cyc = 0;
        go_to(3);
        check_both("restart_c3", {4'b1110, 7'b1000000, 1'b0}, {4'b1110, 7'b1000000, 1'b0});
        go_to(4);
        check_both("restart_c4", {4'b1101, 7'b1111111, 1'b1}, {4'b1101, 7'b1000000, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
